// File: rtl/axi4_mem_arbiter.sv
// Two-requester arbiter in front of a single-port word memory, with burst locking and fixed-latency read return.
// Build option: define AXI4_MEM_ARB_RR_EN for round-robin tie-breaking; otherwise requester 0 has fixed priority.
module axi4_mem_arbiter #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned ADDR_WIDTH = 10
) (
    input  logic                  ACLK,
    input  logic                  ARESETn,
    input  logic                  m0_req,
    input  logic                  m0_we,
    input  logic                  m0_lock,
    input  logic [ADDR_WIDTH-1:0] m0_addr,
    input  logic [DATA_WIDTH-1:0] m0_wdata,
    output logic                  m0_gnt,
    output logic                  m0_rvalid,
    input  logic                  m1_req,
    input  logic                  m1_we,
    input  logic                  m1_lock,
    input  logic [ADDR_WIDTH-1:0] m1_addr,
    input  logic [DATA_WIDTH-1:0] m1_wdata,
    output logic                  m1_gnt,
    output logic                  m1_rvalid,
    output logic [DATA_WIDTH-1:0] rdata,
    output logic                  mem_en,
    output logic                  mem_we,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    input  logic [DATA_WIDTH-1:0] mem_rdata
);

    localparam logic [1:0] ARB_OPEN  = 2'd0;
    localparam logic [1:0] ARB_LOCK0 = 2'd1;
    localparam logic [1:0] ARB_LOCK1 = 2'd2;

    logic [1:0]            arb_state_q, arb_state_d;
`ifdef AXI4_MEM_ARB_RR_EN
    logic                  rr_ptr_q, rr_ptr_d;
`endif
    logic                  gnt0_c, gnt1_c;
    logic                  mem_en_q, mem_en_d;
    logic                  mem_we_q, mem_we_d;
    logic [ADDR_WIDTH-1:0] mem_addr_q, mem_addr_d;
    logic [DATA_WIDTH-1:0] mem_wdata_q, mem_wdata_d;
    // Bit 0 is the stage written at grant, bit 1 is the stage aligned with mem_rdata.
    logic [1:0]            rd_vld_q, rd_vld_d;
    logic [1:0]            rd_id_q, rd_id_d;

    // Same-cycle grant; a lock owner excludes the other requester even while idle.
    always_comb begin : grant_logic
        gnt0_c = 1'b0;
        gnt1_c = 1'b0;
        case (arb_state_q)
            ARB_LOCK0: gnt0_c = m0_req;
            ARB_LOCK1: gnt1_c = m1_req;
            default: begin
                if (m0_req && m1_req) begin
`ifdef AXI4_MEM_ARB_RR_EN
                    gnt0_c = ~rr_ptr_q;
                    gnt1_c = rr_ptr_q;
`else
                    gnt0_c = 1'b1;
`endif
                end else begin
                    gnt0_c = m0_req;
                    gnt1_c = m1_req;
                end
            end
        endcase
        if (!ARESETn) begin
            gnt0_c = 1'b0;
            gnt1_c = 1'b0;
        end
    end

    // Next-state: arbitration state, memory command and read-tracking pipeline.
    always_comb begin : next_state
        arb_state_d = arb_state_q;
`ifdef AXI4_MEM_ARB_RR_EN
        rr_ptr_d    = rr_ptr_q;
`endif
        mem_en_d    = 1'b0;
        mem_we_d    = 1'b0;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        rd_vld_d    = {rd_vld_q[0], 1'b0};
        rd_id_d     = {rd_id_q[0], 1'b0};
        if (gnt0_c) begin
            arb_state_d = m0_lock ? ARB_LOCK0 : ARB_OPEN;
`ifdef AXI4_MEM_ARB_RR_EN
            if (!m0_lock) rr_ptr_d = 1'b1;
`endif
            mem_en_d    = 1'b1;
            mem_we_d    = m0_we;
            mem_addr_d  = m0_addr;
            mem_wdata_d = m0_wdata;
            rd_vld_d[0] = ~m0_we;
            rd_id_d[0]  = 1'b0;
        end else if (gnt1_c) begin
            arb_state_d = m1_lock ? ARB_LOCK1 : ARB_OPEN;
`ifdef AXI4_MEM_ARB_RR_EN
            if (!m1_lock) rr_ptr_d = 1'b0;
`endif
            mem_en_d    = 1'b1;
            mem_we_d    = m1_we;
            mem_addr_d  = m1_addr;
            mem_wdata_d = m1_wdata;
            rd_vld_d[0] = ~m1_we;
            rd_id_d[0]  = 1'b1;
        end
    end

    always_ff @(posedge ACLK) begin : state_regs
        if (!ARESETn) begin
            arb_state_q <= ARB_OPEN;
`ifdef AXI4_MEM_ARB_RR_EN
            rr_ptr_q    <= 1'b0;
`endif
            mem_en_q    <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            rd_vld_q    <= 2'b00;
            rd_id_q     <= 2'b00;
        end else begin
            arb_state_q <= arb_state_d;
`ifdef AXI4_MEM_ARB_RR_EN
            rr_ptr_q    <= rr_ptr_d;
`endif
            mem_en_q    <= mem_en_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            rd_vld_q    <= rd_vld_d;
            rd_id_q     <= rd_id_d;
        end
    end

    assign m0_gnt    = gnt0_c;
    assign m1_gnt    = gnt1_c;
    assign m0_rvalid = rd_vld_q[1] & ~rd_id_q[1];
    assign m1_rvalid = rd_vld_q[1] & rd_id_q[1];
    assign rdata     = mem_rdata;
    assign mem_en    = mem_en_q;
    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;

endmodule

// File: tb/tb_axi4_mem_arbiter.sv
// Self-checking bench for axi4_mem_arbiter: directed scenarios plus randomized traffic against a transaction-level model.
// Expectations follow AXI4_MEM_ARB_RR_EN the same way the design does.
module tb_axi4_mem_arbiter;

    localparam int unsigned DW    = 32;
    localparam int unsigned AW    = 10;
    localparam int unsigned DEPTH = 1 << AW;

    logic          clk = 1'b0;
    logic          rstn;
    logic          m0_req, m0_we, m0_lock, m1_req, m1_we, m1_lock;
    logic [AW-1:0] m0_addr, m1_addr;
    logic [DW-1:0] m0_wdata, m1_wdata;
    logic          m0_gnt, m1_gnt, m0_rvalid, m1_rvalid;
    logic [DW-1:0] rdata;
    logic          mem_en, mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata, mem_rd_q;
    logic [DW-1:0] mem_array [0:DEPTH-1];

    always #5 clk = ~clk;

    axi4_mem_arbiter #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
        .ACLK(clk), .ARESETn(rstn),
        .m0_req(m0_req), .m0_we(m0_we), .m0_lock(m0_lock), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
        .m0_gnt(m0_gnt), .m0_rvalid(m0_rvalid),
        .m1_req(m1_req), .m1_we(m1_we), .m1_lock(m1_lock), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
        .m1_gnt(m1_gnt), .m1_rvalid(m1_rvalid),
        .rdata(rdata), .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rd_q)
    );

    // Single-port memory with registered read data.
    always @(posedge clk) begin
        if (mem_en) begin
            if (mem_we) mem_array[mem_addr] <= mem_wdata;
            else        mem_rd_q <= mem_array[mem_addr];
        end
    end

    typedef struct {
        int            due;
        int            id;
        logic [DW-1:0] data;
    } rd_t;

    int            checks, errors, cyc;
    int            lock_owner, rr;
    logic [DW-1:0] sb_mem [0:DEPTH-1];
    rd_t           pend [$];
    logic          exp_en, exp_we, exp_rv0, exp_rv1;
    logic [AW-1:0] exp_addr;
    logic [DW-1:0] exp_wdata, exp_rdata;

    // Who should be granted for the inputs currently applied: -1 none, 0 or 1.
    function automatic int model_winner();
        if (!rstn) return -1;
        if (lock_owner == 0) return m0_req ? 0 : -1;
        if (lock_owner == 1) return m1_req ? 1 : -1;
        if (m0_req && m1_req) begin
`ifdef AXI4_MEM_ARB_RR_EN
            return rr;
`else
            return 0;
`endif
        end
        if (m0_req) return 0;
        if (m1_req) return 1;
        return -1;
    endfunction

    // Advance one clock and update the model; returns at posedge + 1.
    task automatic tick();
        int            w;
        logic          b_we, b_lock;
        logic [AW-1:0] b_addr;
        logic [DW-1:0] b_data;
        rd_t           r;
        w = model_winner();
        @(posedge clk);
        if (!rstn) begin
            lock_owner = -1; rr = 0;
            exp_en = 1'b0; exp_we = 1'b0; exp_addr = '0; exp_wdata = '0;
            pend.delete();
        end else if (w >= 0) begin
            b_we   = (w == 0) ? m0_we    : m1_we;
            b_lock = (w == 0) ? m0_lock  : m1_lock;
            b_addr = (w == 0) ? m0_addr  : m1_addr;
            b_data = (w == 0) ? m0_wdata : m1_wdata;
            if (b_lock) lock_owner = w;
            else begin lock_owner = -1; rr = 1 - w; end
            exp_en = 1'b1; exp_we = b_we; exp_addr = b_addr; exp_wdata = b_data;
            if (b_we) sb_mem[b_addr] = b_data;
            else begin
                r.due = cyc + 2; r.id = w; r.data = sb_mem[b_addr];
                pend.push_back(r);
            end
        end else begin
            exp_en = 1'b0; exp_we = 1'b0;
        end
        cyc++;
        #1;
        exp_rv0 = 1'b0; exp_rv1 = 1'b0; exp_rdata = '0;
        if (pend.size() > 0 && pend[0].due == cyc) begin
            r = pend.pop_front();
            exp_rv0 = (r.id == 0); exp_rv1 = (r.id == 1); exp_rdata = r.data;
        end
    endtask

    task automatic drv(input int m, input logic req, input logic we, input logic lock,
                       input logic [AW-1:0] a, input logic [DW-1:0] d);
        if (m == 0) begin m0_req = req; m0_we = we; m0_lock = lock; m0_addr = a; m0_wdata = d; end
        else        begin m1_req = req; m1_we = we; m1_lock = lock; m1_addr = a; m1_wdata = d; end
    endtask

    task automatic idle();
        drv(0, 1'b0, 1'b0, 1'b0, '0, '0);
        drv(1, 1'b0, 1'b0, 1'b0, '0, '0);
    endtask

    task automatic test_reset();
        rstn = 1'b0;
        idle();
        m0_req = 1'b1;
        #1;
        checks++;
        if (m0_gnt !== 1'b0 || m1_gnt !== 1'b0) begin
            errors++; $display("FAIL reset_gnt_gated: m0_gnt=%b m1_gnt=%b want 0 0", m0_gnt, m1_gnt);
        end
        tick(); tick();
        checks++;
        if (mem_en !== 1'b0 || mem_we !== 1'b0 || mem_addr !== '0 || mem_wdata !== '0) begin
            errors++; $display("FAIL reset_mem_cmd: en=%b we=%b addr=%h wdata=%h want 0 0 0 0",
                               mem_en, mem_we, mem_addr, mem_wdata);
        end
        checks++;
        if (m0_rvalid !== 1'b0 || m1_rvalid !== 1'b0 || rdata !== mem_rd_q) begin
            errors++; $display("FAIL reset_rd: rv0=%b rv1=%b rdata=%h want 0 0 %h",
                               m0_rvalid, m1_rvalid, rdata, mem_rd_q);
        end
        rstn = 1'b1;
        idle();
        tick();
    endtask

    task automatic test_basic_read();
        drv(0, 1'b1, 1'b0, 1'b0, AW'(5), '0);
        #1;
        checks++;
        if (m0_gnt !== 1'b1 || m1_gnt !== 1'b0) begin
            errors++; $display("FAIL basic_gnt: m0_gnt=%b m1_gnt=%b want 1 0", m0_gnt, m1_gnt);
        end
        tick(); idle();
        checks++;
        if (mem_en !== 1'b1 || mem_we !== 1'b0 || mem_addr !== AW'(5) || m0_rvalid !== 1'b0) begin
            errors++; $display("FAIL basic_cmd: en=%b we=%b addr=%h rv0=%b want 1 0 005 0",
                               mem_en, mem_we, mem_addr, m0_rvalid);
        end
        tick();
        checks++;
        if (m0_rvalid !== 1'b1 || m1_rvalid !== 1'b0 || rdata !== sb_mem[5]) begin
            errors++; $display("FAIL basic_rvalid: rv0=%b rv1=%b rdata=%h want 1 0 %h",
                               m0_rvalid, m1_rvalid, rdata, sb_mem[5]);
        end
        checks++;
        if (mem_en !== 1'b0 || mem_addr !== AW'(5)) begin
            errors++; $display("FAIL basic_idle_hold: en=%b addr=%h want 0 005", mem_en, mem_addr);
        end
        tick();
        checks++;
        if (m0_rvalid !== 1'b0) begin
            errors++; $display("FAIL basic_single_rvalid: rv0=%b want 0", m0_rvalid);
        end
    endtask

    task automatic test_contention();
        int prev;
        prev = -1;
        drv(0, 1'b1, 1'b0, 1'b0, AW'(1), '0);
        drv(1, 1'b1, 1'b0, 1'b0, AW'(2), '0);
        for (int i = 0; i < 8; i++) begin
            int w;
            #1;
            w = model_winner();
            checks++;
            if (m0_gnt !== 1'(w == 0) || m1_gnt !== 1'(w == 1)) begin
                errors++; $display("FAIL contend_gnt[%0d]: m0_gnt=%b m1_gnt=%b want %b %b",
                                   i, m0_gnt, m1_gnt, w == 0, w == 1);
            end
`ifdef AXI4_MEM_ARB_RR_EN
            if (prev >= 0) begin
                checks++;
                if (m0_gnt !== 1'(prev == 1)) begin
                    errors++; $display("FAIL contend_alternate[%0d]: m0_gnt=%b want %b", i, m0_gnt, prev == 1);
                end
            end
`else
            checks++;
            if (m0_gnt !== 1'b1) begin
                errors++; $display("FAIL contend_fixed[%0d]: m0_gnt=%b want 1", i, m0_gnt);
            end
`endif
            prev = m1_gnt ? 1 : 0;
            tick();
            checks++;
            if (m0_rvalid !== exp_rv0 || m1_rvalid !== exp_rv1 || ((exp_rv0 || exp_rv1) && rdata !== exp_rdata)) begin
                errors++; $display("FAIL contend_rd[%0d]: rv0=%b rv1=%b rdata=%h want %b %b %h",
                                   i, m0_rvalid, m1_rvalid, rdata, exp_rv0, exp_rv1, exp_rdata);
            end
        end
        idle(); tick(); tick();
    endtask

    task automatic test_lock_burst();
        for (int i = 0; i < 4; i++) begin
            drv(1, 1'b1, 1'b1, 1'(i != 3), AW'(8 + i), 32'h1000_0000 + DW'(i));
            if (i >= 1) drv(0, 1'b1, 1'b0, 1'b0, AW'(48), '0);
            #1;
            checks++;
            if (m1_gnt !== 1'b1 || m0_gnt !== 1'b0) begin
                errors++; $display("FAIL lock_burst_gnt[%0d]: m0_gnt=%b m1_gnt=%b want 0 1", i, m0_gnt, m1_gnt);
            end
            tick();
            checks++;
            if (mem_en !== 1'b1 || mem_we !== 1'b1 || mem_addr !== AW'(8 + i) ||
                mem_wdata !== 32'h1000_0000 + DW'(i)) begin
                errors++; $display("FAIL lock_burst_cmd[%0d]: en=%b we=%b addr=%h wdata=%h want 1 1 %h %h",
                                   i, mem_en, mem_we, mem_addr, mem_wdata, AW'(8 + i), 32'h1000_0000 + DW'(i));
            end
        end
        drv(1, 1'b0, 1'b0, 1'b0, '0, '0);
        #1;
        checks++;
        if (m0_gnt !== 1'b1) begin
            errors++; $display("FAIL lock_burst_release: m0_gnt=%b want 1", m0_gnt);
        end
        tick(); idle(); tick(); tick();
    endtask

    task automatic test_raw();
        drv(0, 1'b1, 1'b1, 1'b0, AW'(3), 32'hDEAD_BEEF);
        tick();
        drv(0, 1'b1, 1'b0, 1'b0, AW'(3), '0);
        tick(); idle(); tick();
        checks++;
        if (m0_rvalid !== 1'b1 || rdata !== 32'hDEAD_BEEF) begin
            errors++; $display("FAIL raw_data: rv0=%b rdata=%h want 1 deadbeef", m0_rvalid, rdata);
        end
        tick();
    endtask

    task automatic test_reset_mid();
        drv(1, 1'b1, 1'b0, 1'b1, AW'(7), '0);
        #1;
        checks++;
        if (m1_gnt !== 1'b1) begin
            errors++; $display("FAIL rstmid_gnt: m1_gnt=%b want 1", m1_gnt);
        end
        tick(); idle();
        rstn = 1'b0;
        tick();
        rstn = 1'b1;
        checks++;
        if (m1_rvalid !== 1'b0 || m0_rvalid !== 1'b0 || mem_en !== 1'b0 || mem_addr !== '0) begin
            errors++; $display("FAIL rstmid_discard: rv1=%b rv0=%b en=%b addr=%h want 0 0 0 000",
                               m1_rvalid, m0_rvalid, mem_en, mem_addr);
        end
        drv(0, 1'b1, 1'b0, 1'b0, AW'(9), '0);
        #1;
        checks++;
        if (m0_gnt !== 1'b1) begin
            errors++; $display("FAIL rstmid_unlocked: m0_gnt=%b want 1", m0_gnt);
        end
        tick(); idle();
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (m1_rvalid !== 1'b0) begin
                errors++; $display("FAIL rstmid_no_rv1[%0d]: rv1=%b want 0", i, m1_rvalid);
            end
            tick();
        end
    endtask

    task automatic test_lock_stall();
        drv(0, 1'b1, 1'b1, 1'b1, AW'(64), 32'hA5A5_0040);
        tick();
        drv(0, 1'b0, 1'b0, 1'b0, '0, '0);
        drv(1, 1'b1, 1'b0, 1'b0, AW'(80), '0);
        for (int i = 0; i < 3; i++) begin
            #1;
            checks++;
            if (m0_gnt !== 1'b0 || m1_gnt !== 1'b0) begin
                errors++; $display("FAIL stall_gnt[%0d]: m0_gnt=%b m1_gnt=%b want 0 0", i, m0_gnt, m1_gnt);
            end
            tick();
            checks++;
            if (mem_en !== 1'b0 || mem_we !== 1'b0 || mem_addr !== AW'(64)) begin
                errors++; $display("FAIL stall_cmd[%0d]: en=%b we=%b addr=%h want 0 0 040", i, mem_en, mem_we, mem_addr);
            end
        end
        drv(0, 1'b1, 1'b1, 1'b0, AW'(65), 32'hA5A5_0041);
        #1;
        checks++;
        if (m0_gnt !== 1'b1 || m1_gnt !== 1'b0) begin
            errors++; $display("FAIL stall_final_beat: m0_gnt=%b m1_gnt=%b want 1 0", m0_gnt, m1_gnt);
        end
        tick();
        drv(0, 1'b0, 1'b0, 1'b0, '0, '0);
        #1;
        checks++;
        if (m1_gnt !== 1'b1) begin
            errors++; $display("FAIL stall_released: m1_gnt=%b want 1", m1_gnt);
        end
        tick(); idle(); tick(); tick();
    endtask

    task automatic test_random();
        for (int i = 0; i < 600; i++) begin
            int w;
            rstn = ($urandom_range(0, 63) != 0);
            drv(0, 1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 2) == 0),
                AW'($urandom_range(0, 15)), DW'($urandom));
            drv(1, 1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 2) == 0),
                AW'($urandom_range(0, 15)), DW'($urandom));
            #1;
            w = model_winner();
            checks++;
            if (m0_gnt !== 1'(w == 0) || m1_gnt !== 1'(w == 1)) begin
                errors++; $display("FAIL rnd_gnt[%0d]: m0_gnt=%b m1_gnt=%b want %b %b",
                                   i, m0_gnt, m1_gnt, w == 0, w == 1);
            end
            tick();
            checks++;
            if (mem_en !== exp_en || mem_we !== exp_we || mem_addr !== exp_addr || mem_wdata !== exp_wdata) begin
                errors++; $display("FAIL rnd_cmd[%0d]: en=%b we=%b addr=%h wdata=%h want %b %b %h %h",
                                   i, mem_en, mem_we, mem_addr, mem_wdata, exp_en, exp_we, exp_addr, exp_wdata);
            end
            checks++;
            if (m0_rvalid !== exp_rv0 || m1_rvalid !== exp_rv1 || ((exp_rv0 || exp_rv1) && rdata !== exp_rdata)) begin
                errors++; $display("FAIL rnd_rd[%0d]: rv0=%b rv1=%b rdata=%h want %b %b %h",
                                   i, m0_rvalid, m1_rvalid, rdata, exp_rv0, exp_rv1, exp_rdata);
            end
        end
        rstn = 1'b1;
        idle(); tick(); tick(); tick();
    endtask

    initial begin
        checks = 0; errors = 0; cyc = 0;
        lock_owner = -1; rr = 0;
        exp_en = 1'b0; exp_we = 1'b0; exp_addr = '0; exp_wdata = '0;
        exp_rv0 = 1'b0; exp_rv1 = 1'b0; exp_rdata = '0;
        for (int i = 0; i < int'(DEPTH); i++) begin
            logic [DW-1:0] v;
            v = DW'($urandom);
            mem_array[i] <= v;
            sb_mem[i] = v;
        end
        test_reset();
        test_basic_read();
        test_contention();
        test_lock_burst();
        test_raw();
        test_reset_mid();
        test_lock_stall();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
